// File: rtl/lvl_states_manager_pkg.sv
// Shared definitions for the level-states manager: FSM encodings, the
// layout of one level-states BRAM word and the deepest usable level.
// Optional feature macro: LSM_CLEAR_ON_ROLLBACK_EN (see lvl_states_manager.sv).
package lvl_states_manager_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PUSH  = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Level-states word: has_bkt flag at bit 0, bin id in the bits above it
   localparam int unsigned LS_HAS_BKT_BIT = 0;
   localparam int unsigned LS_BIN_LSB     = 1;

   // Level L lives at BRAM address L, so the top address is the deepest level
   function automatic int unsigned calc_max_lvl(input int unsigned addr_w);
      return (32'd1 << addr_w) - 32'd1;
   endfunction

endpackage

// File: rtl/lvl_clear_walker.sv
// Descending address counter used to sweep level-states entries during a
// rollback clear.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        load first_addr and count
//   step         move to the next lower address, consuming one count
//   first_addr   address presented after start
//   count        number of steps still available after start
//   addr         current address (registered)
//   done_c       no steps left (combinational)
module lvl_clear_walker
   import lvl_states_manager_pkg::*;
#(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] addr,
   output logic              done_c
);

   logic [CNT_W-1:0] rem_q;

   // Address and remaining-count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr  <= '0;
         rem_q <= '0;
      end else if (start) begin
         addr  <= first_addr;
         rem_q <= count;
      end else if (step) begin
         addr  <= addr - ADDR_W'(1);
         rem_q <= rem_q - CNT_W'(1);
      end
   end

   assign done_c = (rem_q == '0);

endmodule

// File: rtl/lvl_states_manager.sv
// Write side of the level-states BRAM: records a {bin, has_bkt} word for each
// new decision level and rewinds the decision level on rollback.
// Build option: LSM_CLEAR_ON_ROLLBACK_EN defined -> rollback zeroes every
// entry above the target level (CLEAR state); undefined -> lazy rollback,
// stale entries are simply overwritten by later pushes.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start_push, push_bin_i        one-cycle push request and deciding bin
//   start_rollback, bkt_lvl_i     one-cycle rollback request and target level
//   apply_o                       block owns the BRAM write port
//   done_o                        one-cycle completion pulse
//   cur_lvl_o                     current decision level (0 = none)
//   overflow_o                    sticky, push attempted at the deepest level
//   ram_we_ls_o/waddr/wdata       BRAM write port
module lvl_states_manager
   import lvl_states_manager_pkg::*;
#(
   parameter int unsigned WIDTH_LVL             = 16,
   parameter int unsigned WIDTH_BIN_ID          = 10,
   parameter int unsigned WIDTH_LVL_STATES      = 11,
   parameter int unsigned ADDR_WIDTH_LVL_STATES = 9
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_push,
   input  logic [WIDTH_BIN_ID-1:0]          push_bin_i,
   input  logic                             start_rollback,
   input  logic [WIDTH_LVL-1:0]             bkt_lvl_i,
   output logic                             apply_o,
   output logic                             done_o,
   output logic [WIDTH_LVL-1:0]             cur_lvl_o,
   output logic                             overflow_o,
   output logic                             ram_we_ls_o,
   output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_waddr_ls_o,
   output logic [WIDTH_LVL_STATES-1:0]      ram_wdata_ls_o
);

   localparam logic [WIDTH_LVL-1:0] MAX_LVL =
      WIDTH_LVL'(calc_max_lvl(ADDR_WIDTH_LVL_STATES));

   logic [1:0]                       state_q, state_nxt;
   logic [WIDTH_LVL-1:0]             cur_lvl_nxt;
   logic                             ovf_nxt;
   logic                             we_nxt;
   logic [ADDR_WIDTH_LVL_STATES-1:0] waddr_nxt;
   logic [WIDTH_LVL_STATES-1:0]      wdata_nxt;
   logic                             roll_n_zero_c;
   logic [WIDTH_LVL-1:0]             roll_lvl_c;

   // Nothing to unwind when the target is at or above the current level
   assign roll_n_zero_c = (bkt_lvl_i >= cur_lvl_o);
   assign roll_lvl_c    = roll_n_zero_c ? cur_lvl_o : bkt_lvl_i;

`ifdef LSM_CLEAR_ON_ROLLBACK_EN
   logic [WIDTH_LVL-1:0]             bkt_q;
   logic                             walk_start, walk_step, walk_done_c;
   logic [ADDR_WIDTH_LVL_STATES-1:0] walk_addr;
   logic [ADDR_WIDTH_LVL_STATES-1:0] walk_first_c;
   logic [WIDTH_LVL-1:0]             walk_count_c;

   // The FSM issues the first clear (address cur_lvl) itself on the start
   // cycle; the walker is loaded with the remaining N-1 addresses below it.
   assign walk_first_c = ADDR_WIDTH_LVL_STATES'(cur_lvl_o - WIDTH_LVL'(1));
   assign walk_count_c = cur_lvl_o - bkt_lvl_i - WIDTH_LVL'(1);

   lvl_clear_walker #(
      .ADDR_W (ADDR_WIDTH_LVL_STATES),
      .CNT_W  (WIDTH_LVL)
   ) u_clear_walker (
      .clk        (clk),
      .rst        (rst),
      .start      (walk_start),
      .step       (walk_step),
      .first_addr (walk_first_c),
      .count      (walk_count_c),
      .addr       (walk_addr),
      .done_c     (walk_done_c)
   );
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state and next values of the registered outputs
   always_comb begin
      state_nxt   = state_q;
      cur_lvl_nxt = cur_lvl_o;
      ovf_nxt     = overflow_o;
      we_nxt      = 1'b0;
      waddr_nxt   = '0;
      wdata_nxt   = '0;
`ifdef LSM_CLEAR_ON_ROLLBACK_EN
      walk_start  = 1'b0;
      walk_step   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // Rollback has priority over a simultaneous push
            if (start_rollback) begin
               state_nxt   = ST_DONE;
               cur_lvl_nxt = roll_lvl_c;
`ifdef LSM_CLEAR_ON_ROLLBACK_EN
               if (!roll_n_zero_c) begin
                  state_nxt   = ST_CLEAR;
                  cur_lvl_nxt = cur_lvl_o;
                  walk_start  = 1'b1;
                  we_nxt      = 1'b1;
                  waddr_nxt   = ADDR_WIDTH_LVL_STATES'(cur_lvl_o);
               end
`endif
            end else if (start_push) begin
               state_nxt = ST_PUSH;
               if (cur_lvl_o == MAX_LVL) begin
                  ovf_nxt = 1'b1;
               end else begin
                  cur_lvl_nxt = cur_lvl_o + WIDTH_LVL'(1);
                  we_nxt      = 1'b1;
                  waddr_nxt   = ADDR_WIDTH_LVL_STATES'(cur_lvl_o + WIDTH_LVL'(1));
                  wdata_nxt[WIDTH_LVL_STATES-1:LS_BIN_LSB] = push_bin_i;
                  wdata_nxt[LS_HAS_BKT_BIT]                = 1'b0;
               end
            end
         end
         ST_PUSH: begin
            state_nxt = ST_DONE;
         end
`ifdef LSM_CLEAR_ON_ROLLBACK_EN
         ST_CLEAR: begin
            if (walk_done_c) begin
               state_nxt   = ST_DONE;
               cur_lvl_nxt = bkt_q;
            end else begin
               walk_step = 1'b1;
               we_nxt    = 1'b1;
               waddr_nxt = walk_addr;
            end
         end
`endif
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         apply_o        <= 1'b0;
         done_o         <= 1'b0;
         cur_lvl_o      <= '0;
         overflow_o     <= 1'b0;
         ram_we_ls_o    <= 1'b0;
         ram_waddr_ls_o <= '0;
         ram_wdata_ls_o <= '0;
      end else begin
         apply_o        <= (state_nxt != ST_IDLE);
         done_o         <= (state_nxt == ST_DONE);
         cur_lvl_o      <= cur_lvl_nxt;
         overflow_o     <= ovf_nxt;
         ram_we_ls_o    <= we_nxt;
         ram_waddr_ls_o <= waddr_nxt;
         ram_wdata_ls_o <= wdata_nxt;
      end
   end

`ifdef LSM_CLEAR_ON_ROLLBACK_EN
   // Rollback target, held for the end of the clear sweep
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bkt_q <= '0;
      end else if (walk_start) begin
         bkt_q <= bkt_lvl_i;
      end
   end
`endif

endmodule

// File: tb/tb_lvl_states_manager.sv
// Self-checking bench for lvl_states_manager: directed vector table,
// random operations against a level-stack reference model, overflow fill
// and asynchronous reset in the middle of a rollback.
module tb_lvl_states_manager;

   localparam int unsigned WL   = 16;
   localparam int unsigned WB   = 10;
   localparam int unsigned WLS  = 11;
   localparam int unsigned AW   = 9;
   localparam int          MAXL = 511;

`ifdef LSM_CLEAR_ON_ROLLBACK_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_push = 1'b0;
   logic [WB-1:0] push_bin_i = '0;
   logic          start_rollback = 1'b0;
   logic [WL-1:0] bkt_lvl_i = '0;
   logic          apply_o, done_o, overflow_o, ram_we_ls_o;
   logic [WL-1:0] cur_lvl_o;
   logic [AW-1:0] ram_waddr_ls_o;
   logic [WLS-1:0] ram_wdata_ls_o;

   lvl_states_manager #(
      .WIDTH_LVL             (WL),
      .WIDTH_BIN_ID          (WB),
      .WIDTH_LVL_STATES      (WLS),
      .ADDR_WIDTH_LVL_STATES (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_push     (start_push),
      .push_bin_i     (push_bin_i),
      .start_rollback (start_rollback),
      .bkt_lvl_i      (bkt_lvl_i),
      .apply_o        (apply_o),
      .done_o         (done_o),
      .cur_lvl_o      (cur_lvl_o),
      .overflow_o     (overflow_o),
      .ram_we_ls_o    (ram_we_ls_o),
      .ram_waddr_ls_o (ram_waddr_ls_o),
      .ram_wdata_ls_o (ram_wdata_ls_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Observed BRAM writes: {addr, data}
   logic [AW+WLS-1:0] act_wr[$];
   always @(negedge clk) begin
      if (ram_we_ls_o === 1'b1) act_wr.push_back({ram_waddr_ls_o, ram_wdata_ls_o});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a stack of decision levels
   int                m_cur = 0;
   bit                m_ovf = 1'b0;
   int                exp_lat;
   logic [AW+WLS-1:0] exp_wr[$];

   function automatic void model_op(input bit p, input bit r, input logic [WB-1:0] bin, input int bkt);
      exp_wr.delete();
      if (r) begin
         exp_lat = 1;
         if (bkt < m_cur) begin
            if (CLEAR_EN) begin
               for (int l = m_cur; l > bkt; l--) exp_wr.push_back({AW'(l), WLS'(0)});
               exp_lat = m_cur - bkt + 1;
            end
            m_cur = bkt;
         end
      end else if (p) begin
         exp_lat = 2;
         if (m_cur == MAXL) begin
            m_ovf = 1'b1;
         end else begin
            m_cur++;
            exp_wr.push_back({AW'(m_cur), bin, 1'b0});
         end
      end
   endfunction

   int last_lat;
   int last_nwr;

   // Issue one request at cycle T, optionally pulse start_push again at T+1
   // (must be ignored), then compare timing, level and writes to the model.
   task automatic do_op(input string name, input bit p, input bit r,
                        input logic [WB-1:0] bin, input logic [WL-1:0] bkt, input bit noise);
      int            lat;
      logic [WL-1:0] cur1;
      logic [WL-1:0] cur_done;
      bit            apply_bad;
      int            n;
      model_op(p, r, bin, int'(bkt));
      act_wr.delete();
      lat = 0;
      apply_bad = 1'b0;
      cur1 = '0;
      cur_done = '0;
      @(posedge clk); #1;
      start_push = p; start_rollback = r; push_bin_i = bin; bkt_lvl_i = bkt;
      @(posedge clk); #1;
      start_push = noise; start_rollback = 1'b0;
      push_bin_i = WB'($urandom); bkt_lvl_i = WL'($urandom);
      for (int k = 1; k <= 700; k++) begin
         @(negedge clk);
         if (k == 1) cur1 = cur_lvl_o;
         if (apply_o !== 1'b1) apply_bad = 1'b1;
         if (done_o === 1'b1) begin
            lat = k;
            cur_done = cur_lvl_o;
            break;
         end
         @(posedge clk); #1;
         start_push = 1'b0;
      end
      @(posedge clk); #1;
      start_push = 1'b0;
      @(negedge clk);
      check({name, " done latency"}, 64'(lat), 64'(exp_lat));
      check({name, " apply during op"}, 64'(apply_bad), 64'd0);
      check({name, " idle after done"}, {62'd0, apply_o, done_o}, 64'd0);
      check({name, " cur_lvl at done"}, 64'(cur_done), 64'(m_cur));
      check({name, " overflow"}, 64'(overflow_o), 64'(m_ovf));
      if (p && !r) check({name, " cur_lvl at T+1"}, 64'(cur1), 64'(m_cur));
      check({name, " write count"}, 64'(act_wr.size()), 64'(exp_wr.size()));
      n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
      for (int i = 0; i < n; i++) check({name, " write addr/data"}, 64'(act_wr[i]), 64'(exp_wr[i]));
      last_lat = lat;
      last_nwr = act_wr.size();
   endtask

   typedef struct {
      bit            p;
      bit            r;
      logic [WB-1:0] bin;
      logic [WL-1:0] bkt;
      int            cur;
      int            lat_clr;
      int            lat_lazy;
      int            nwr_clr;
      int            nwr_lazy;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 10'd5,     16'd0, 1, 2, 2, 1, 1};
      vecs[1] = '{1'b1, 1'b0, 10'd7,     16'd0, 2, 2, 2, 1, 1};
      vecs[2] = '{1'b1, 1'b0, 10'd9,     16'd0, 3, 2, 2, 1, 1};
      vecs[3] = '{1'b0, 1'b1, 10'd0,     16'd1, 1, 3, 1, 2, 0};
      vecs[4] = '{1'b0, 1'b1, 10'd0,     16'd4, 1, 1, 1, 0, 0};
      vecs[5] = '{1'b1, 1'b0, 10'h0AA,   16'd0, 2, 2, 2, 1, 1};
      vecs[6] = '{1'b1, 1'b1, 10'h155,   16'd0, 0, 3, 1, 2, 0};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs",
            {48'd0, cur_lvl_o},
            64'd0);
      check("reset flags",
            {59'd0, apply_o, done_o, overflow_o, ram_we_ls_o, 1'b0},
            64'd0);
      check("reset write port", {44'd0, ram_waddr_ls_o, ram_wdata_ls_o}, 64'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].p, vecs[i].r, vecs[i].bin, vecs[i].bkt, 1'b0);
         check($sformatf("vec%0d table cur_lvl", i), 64'(cur_lvl_o), 64'(vecs[i].cur));
         check($sformatf("vec%0d table latency", i), 64'(last_lat),
               64'(CLEAR_EN ? vecs[i].lat_clr : vecs[i].lat_lazy));
         check($sformatf("vec%0d table writes", i), 64'(last_nwr),
               64'(CLEAR_EN ? vecs[i].nwr_clr : vecs[i].nwr_lazy));
      end

      // Random mix, including simultaneous starts and ignored mid-op starts
      for (int i = 0; i < 200; i++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         do_op("rand", (sel < 6) || (sel == 9), sel >= 6, WB'($urandom),
               WL'($urandom_range(0, m_cur + 3)), 1'($urandom));
      end

      // Fill to the deepest level, then one push too many
      while (m_cur < MAXL) do_op("fill", 1'b1, 1'b0, WB'($urandom), '0, 1'b0);
      do_op("overflow push", 1'b1, 1'b0, 10'h3C3, '0, 1'b0);
      check("overflow set", 64'(overflow_o), 64'd1);
      check("cur at max", 64'(cur_lvl_o), 64'(MAXL));

      // Asynchronous reset in the middle of a rollback
      @(posedge clk); #1;
      start_rollback = 1'b1; bkt_lvl_i = '0;
      @(posedge clk); #1;
      start_rollback = 1'b0;
      #2;
      check("rollback in progress", 64'(apply_o), 64'd1);
      rst = 1'b0;
      #1;
      check("async reset clears",
            {59'd0, ram_we_ls_o, apply_o, overflow_o, done_o, |cur_lvl_o}, 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      m_cur = 0;
      m_ovf = 1'b0;
      do_op("push after reset", 1'b1, 1'b0, 10'd33, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lvl_states_manager.md
# lvl_states_manager

Maintains the level-states BRAM, one `{dcd_bin, has_bkt}` word per decision level, and the current decision level counter.
- **Push:** on a new decision, writes the entry for the new level.
- **Rollback:** after the global backtrack level is known, clears every entry above that level and rewinds the level counter.

It sits on the write side of the lvl-states BRAM. Its push path feeds the global-backtrack-level search. Its rollback path consumes that search's result (`bkt_lvl`) once the search reports done.

## Interface
Parameters:
- `WIDTH_LVL`, 16, width of level values
- `WIDTH_BIN_ID`, 10, width of bin id
- `WIDTH_LVL_STATES`, 11, BRAM word width; must equal `WIDTH_BIN_ID+1`
- `ADDR_WIDTH_LVL_STATES`, 9, BRAM address width; highest usable level is `MAX_LVL = 2^ADDR_WIDTH_LVL_STATES-1`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-low
- `start_push`  in  1  single-cycle request to record a new decision level
- `push_bin_i`  in  `WIDTH_BIN_ID`  bin that made the decision
- `start_rollback`  in  1  single-cycle request to roll back
- `bkt_lvl_i`  in  `WIDTH_LVL`  target level; must be held stable in the cycle `start_rollback` is high
- `apply_o`  out  1  high while the block owns the BRAM write port (drives the BRAM mux)
- `done_o`  out  1  one-cycle completion pulse
- `cur_lvl_o`  out  `WIDTH_LVL`  current decision level; 0 means no decisions
- `overflow_o`  out  1  sticky; set by a push while `cur_lvl_o == MAX_LVL`
- `ram_we_ls_o`  out  1  BRAM write enable
- `ram_waddr_ls_o`  out  `ADDR_WIDTH_LVL_STATES`  BRAM write address; level L is stored at address L
- `ram_wdata_ls_o`  out  `WIDTH_LVL_STATES`  `{bin, has_bkt}`

## Operation
- **Reset values:** every output is 0, including `cur_lvl_o`; state is `IDLE`.
- **States:** `IDLE`, `PUSH`, `CLEAR`, `DONE`.
- **Start sampling:** starts are sampled only in `IDLE`; starts arriving in any other state are ignored.
- **Simultaneous starts:** if `start_push` and `start_rollback` are high together, rollback wins and the push is dropped.
- **Push (IDLE→PUSH→DONE→IDLE):**
  - Increment `cur_lvl`.
  - Write `{push_bin_i, 1'b0}` to address `cur_lvl+1`.
- **Push at `cur_lvl == MAX_LVL`:** set `overflow_o`, perform no write, leave `cur_lvl` unchanged, still pulse `done_o`.
- **Rollback:**
  - Compute `N = cur_lvl - bkt_lvl_i` (unsigned, `WIDTH_LVL` bits) when `bkt_lvl_i < cur_lvl`; otherwise `N = 0`.
  - If `N > 0`: go IDLE→CLEAR. Write `0` to addresses `cur_lvl`, `cur_lvl-1`, …, `bkt_lvl_i+1`, one per cycle, descending. Then go to `DONE`.
  - If `N == 0`: go IDLE→DONE directly, with no writes and `cur_lvl` unchanged.
  - `cur_lvl` takes the value `min(bkt_lvl_i, cur_lvl)` on entry to `DONE`.
- **bkt_lvl_i latching:** `bkt_lvl_i` is latched on the start cycle; later changes on the input have no effect.
- **overflow_o clearing:** cleared only by reset.
- **Reset mid-operation:** all state, counters and outputs clear immediately (asynchronous), including `ram_we_ls_o`. A partially completed clear is abandoned.

## Timing
- All outputs are registered.
- **Push:** with start at cycle T:
  - `ram_we_ls_o` is high in T+1.
  - `cur_lvl_o` shows the new value from T+1.
  - `done_o` is high in T+2.
- **Rollback with N > 0:** with start at cycle T:
  - Writes occur in T+1 … T+N.
  - `cur_lvl_o` equals `bkt_lvl_i` and `done_o` is high in T+N+1.
- **Rollback with N = 0:** `done_o` is high in T+1.
- **apply_o:** high from T+1 through the `DONE` cycle inclusive, low otherwise.
- **Back-to-back requests:** the earliest next accepted start is the cycle after `done_o`.

## Configuration
- Macro: `LSM_CLEAR_ON_ROLLBACK_EN`.
- **Defined:** rollback clears entries as described above (state `CLEAR`).
- **Undefined:**
  - `CLEAR` is not built; rollback is lazy, with no BRAM writes.
  - Rollback goes IDLE→DONE, so `done_o` is high in T+1.
  - `cur_lvl` is updated the same way.
  - Stale entries are overwritten by later pushes.

## Structure
- **Shared package holds:**
  - state encodings
  - lvl-states word layout: `has_bkt` at bit 0, bin id above
  - `MAX_LVL` derivation
- **Sub-module:** one, `lvl_clear_walker`. It is a descending address counter with start, count and done; it is omitted when the macro is undefined.

## Test plan
- Reset, then push bins 5, 7, 9:
  - Writes: addr 1 ← `{5,0}`, addr 2 ← `{7,0}`, addr 3 ← `{9,0}`.
  - `cur_lvl_o == 3`; three `done_o` pulses, each 2 cycles after its start.
- From `cur_lvl_o == 3`, rollback with `bkt_lvl_i = 1` (macro defined):
  - Writes: addr 3 ← 0, then addr 2 ← 0.
  - `done_o` at T+3, `cur_lvl_o == 1`, `apply_o` high for T+1..T+3.
- Rollback with `bkt_lvl_i = 4` while `cur_lvl_o == 1`:
  - No writes; `done_o` at T+1; `cur_lvl_o` stays 1.
- Drive `start_push` and `start_rollback` (`bkt_lvl_i = 0`) together at `cur_lvl_o == 2`:
  - Rollback executes and the push is dropped.
  - `cur_lvl_o == 0`; no write carries the `push_bin_i` value.
- Fill to `MAX_LVL = 511`, then push once more:
  - `overflow_o == 1`, no write, `cur_lvl_o == 511`.
  - Afterwards, assert `rst` low mid-rollback: `ram_we_ls_o`, `cur_lvl_o`, `apply_o` and `overflow_o` go to 0 immediately.
- Macro undefined, rollback from 5 to 2:
  - No writes; `done_o` at T+1; `cur_lvl_o == 2`.
